alu_mc: RTL and testbench

Parametrised multi-cycle ALU with valid/ready handshakes on input and output, a full-width multiply result, a sequential divider and status flags. It is the next-generation replacement for the original 8-bit single-cycle ALU in the datapath. Accepted operations produce exactly one result transaction each, in order. Output backpressure stalls the block.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_div_seq.sv | 62 ++++++
 rtl/alu_mc.sv | 147 ++++++++++++++
 tb/tb_alu_mc.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag types for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, done pulses with results ready.
module alu_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    // Returns {remainder, quotient} after one shift-and-subtract step.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        sh   = {r, q[WIDTH-1]};
        diff = sh - {1'b0, d};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        else
            return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    // The first iteration is folded into the load so the last one lands
    // WIDTH-1 edges later and done can feed the output register directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remainder <= '0;
            quotient  <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {remainder, quotient} <= div_step('0, dividend, divisor);
                dvs_q <= divisor;
                cnt_q <= CW'(WIDTH - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                {remainder, quotient} <= div_step(remainder, quotient, dvs_q);
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle datapath, divide FSM and handshaked output register.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_result_hi,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_err
);
    localparam int SW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    alu_flags_t       flags_q, c_flags;
    logic             accept, div_start, div_busy, div_done, is_mod_q;
    logic [WIDTH-1:0] div_quo, div_rem, div_res, div_hi;
    logic [WIDTH-1:0] c_res, c_hi;
    logic [WIDTH:0]   sum, diff, shl_w, shr_w;
    logic [2*WIDTH-1:0] prod;
    logic [SW-1:0]    amt;

    assign in_ready  = (state_q == IDLE) && !div_busy && (!out_valid || out_ready) && !reset;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && ((in_op == OP_DIV) || (in_op == OP_MOD)) && (in_b != '0);

    assign amt   = in_b[SW-1:0];
    assign sum   = {1'b0, in_a} + {1'b0, in_b};
    assign diff  = {1'b0, in_a} - {1'b0, in_b};
    assign prod  = in_a * in_b;
    assign shl_w = {1'b0, in_a} << amt;
    assign shr_w = {in_a, 1'b0} >> amt;

    always_comb begin
        c_res   = '0;
        c_hi    = '0;
        c_flags = '0;
        case (in_op)
            OP_ADD: begin
                c_res         = sum[WIDTH-1:0];
                c_flags.carry = sum[WIDTH];
                c_flags.ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                c_res         = diff[WIDTH-1:0];
                c_flags.carry = diff[WIDTH];
                c_flags.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_MUL: begin
                {c_hi, c_res} = prod;
                c_flags.ovf   = (prod[2*WIDTH-1:WIDTH] != '0);
            end
            // Only reached with a zero divisor; non-zero divisors go to the divider.
            OP_DIV, OP_MOD: begin
                c_res       = '1;
                c_hi        = in_a;
                c_flags.err = 1'b1;
            end
            OP_AND: c_res = in_a & in_b;
            OP_OR:  c_res = in_a | in_b;
            OP_XOR: c_res = in_a ^ in_b;
            OP_SHL: begin
                c_res         = shl_w[WIDTH-1:0];
                c_flags.carry = shl_w[WIDTH];
            end
            OP_SHR: begin
                c_res         = shr_w[WIDTH:1];
                c_flags.carry = shr_w[0];
            end
            default: c_flags.err = 1'b1;
        endcase
        c_flags.zero = (c_res == '0);
    end

    alu_div_seq #(.WIDTH(WIDTH)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (in_a),
        .divisor   (in_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign div_res = is_mod_q ? div_rem : div_quo;
    assign div_hi  = is_mod_q ? div_quo : div_rem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_start) state_d = DIV;
            DIV:     if (div_done) state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A divide accepted on a consuming edge falls through to the consume branch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_result_hi <= '0;
            flags_q       <= '0;
            is_mod_q      <= 1'b0;
        end else begin
            if (div_start) is_mod_q <= (in_op == OP_MOD);
            if (accept && !div_start) begin
                out_valid     <= 1'b1;
                out_result    <= c_res;
                out_result_hi <= c_hi;
                flags_q       <= c_flags;
            end else if (div_done) begin
                out_valid     <= 1'b1;
                out_result    <= div_res;
                out_result_hi <= div_hi;
                flags_q       <= '{carry: 1'b0, zero: (div_res == '0), ovf: 1'b0, err: 1'b0};
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_carry = flags_q.carry;
    assign out_zero  = flags_q.zero;
    assign out_ovf   = flags_q.ovf;
    assign out_err   = flags_q.err;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, handshake corner cases, random ops vs model.
module tb_alu_mc;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clock = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready;
    logic         out_carry, out_zero, out_ovf, out_err;
    logic [W-1:0] in_a, in_b, out_result, out_result_hi;
    logic [3:0]   in_op;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         carry;
        logic         zero;
        logic         ovf;
        logic         err;
    } res_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         exp;
    } vec_t;

    vec_t vecs[20];

    always #5 clock = ~clock;

    alu_mc #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_op         (in_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_result_hi (out_result_hi),
        .out_carry     (out_carry),
        .out_zero      (out_zero),
        .out_ovf       (out_ovf),
        .out_err       (out_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference computed with plain integer arithmetic from the opcode definitions.
    function automatic res_t model(int op, int a, int b);
        res_t r;
        int s, n;
        r = '0;
        case (op)
            0: begin
                s = a + b;
                r.res = W'(s % M);
                r.carry = (s >= M);
                s = sgn(a) + sgn(b);
                r.ovf = (s > M / 2 - 1) || (s < -M / 2);
            end
            1: begin
                r.res = W'((a - b + M) % M);
                r.carry = (a < b);
                s = sgn(a) - sgn(b);
                r.ovf = (s > M / 2 - 1) || (s < -M / 2);
            end
            2: begin
                s = a * b;
                r.res = W'(s % M);
                r.hi = W'(s / M);
                r.ovf = (s / M) != 0;
            end
            3, 4: begin
                if (b == 0) begin
                    r.res = W'(M - 1);
                    r.hi = W'(a);
                    r.err = 1'b1;
                end else if (op == 3) begin
                    r.res = W'(a / b);
                    r.hi = W'(a % b);
                end else begin
                    r.res = W'(a % b);
                    r.hi = W'(a / b);
                end
            end
            5: r.res = W'(a & b);
            6: r.res = W'(a | b);
            7: r.res = W'(a ^ b);
            8: begin
                n = b % W;
                r.res = W'((a * (1 << n)) % M);
                r.carry = (n == 0) ? 1'b0 : 1'(((a >> (W - n)) & 1));
            end
            9: begin
                n = b % W;
                r.res = W'(a >> n);
                r.carry = (n == 0) ? 1'b0 : 1'(((a >> (n - 1)) & 1));
            end
            default: r.err = 1'b1;
        endcase
        r.zero = (r.res == '0);
        return r;
    endfunction

    function automatic vec_t mk(int op, int a, int b, int res, int hi, bit c, bit z, bit o, bit e);
        vec_t v;
        v.op = 4'(op);
        v.a = W'(a);
        v.b = W'(b);
        v.exp = '{res: W'(res), hi: W'(hi), carry: c, zero: z, ovf: o, err: e};
        return v;
    endfunction

    function automatic res_t outs();
        return '{res: out_result, hi: out_result_hi, carry: out_carry,
                 zero: out_zero, ovf: out_ovf, err: out_err};
    endfunction

    // Issues one op, returns outputs and k where out_valid first appears after accept edge + k.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output res_t r, output int k, output bit rdy_low);
        int n;
        @(negedge clock);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_op = 4'($urandom);
        in_a = W'($urandom);
        in_b = W'($urandom);
        k = 0;
        rdy_low = 1'b1;
        forever begin
            @(negedge clock);
            if (out_valid || k > 100) break;
            if (in_ready) rdy_low = 1'b0;
            k++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
        r = outs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r, e;
        int k, seen;
        bit rl;
        logic [3:0] op;
        logic [W-1:0] a, b;

        vecs[0]  = mk(0, 200, 100, 8'h2C, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 5, 7, 8'hFE, 0, 1, 0, 0, 0);
        vecs[2]  = mk(1, 8'h80, 1, 8'h7F, 0, 0, 0, 1, 0);
        vecs[3]  = mk(2, 16, 20, 8'h40, 8'h01, 0, 0, 1, 0);
        vecs[4]  = mk(2, 0, 255, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(3, 200, 7, 8'h1C, 8'h04, 0, 0, 0, 0);
        vecs[6]  = mk(3, 9, 0, 8'hFF, 8'h09, 0, 0, 0, 1);
        vecs[7]  = mk(4, 200, 7, 8'h04, 8'h1C, 0, 0, 0, 0);
        vecs[8]  = mk(4, 0, 5, 0, 0, 0, 1, 0, 0);
        vecs[9]  = mk(5, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0);
        vecs[10] = mk(6, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 0, 0);
        vecs[11] = mk(7, 8'hF0, 8'hF0, 0, 0, 0, 1, 0, 0);
        vecs[12] = mk(8, 8'h81, 1, 8'h02, 0, 1, 0, 0, 0);
        vecs[13] = mk(8, 8'h81, 8, 8'h81, 0, 0, 0, 0, 0);
        vecs[14] = mk(9, 8'h81, 1, 8'h40, 0, 1, 0, 0, 0);
        vecs[15] = mk(9, 8'h80, 7, 8'h01, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 8'h7F, 1, 8'h80, 0, 0, 0, 1, 0);
        vecs[17] = mk(12, 3, 4, 0, 0, 0, 1, 0, 1);
        vecs[18] = mk(15, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 1);
        vecs[19] = mk(3, 8'hFF, 1, 8'hFF, 0, 0, 0, 0, 0);

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_op = '0;
        in_a = '0;
        in_b = '0;

        @(negedge clock);
        check("reset_outputs", {out_valid, outs()}, '0);
        check("reset_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, k, rl);
            check($sformatf("vec%0d_out", i), r, vecs[i].exp);
            if ((vecs[i].op == 3 || vecs[i].op == 4) && vecs[i].b != 0) begin
                check($sformatf("vec%0d_latency", i), k, W);
                check($sformatf("vec%0d_busy_ready", i), rl, 1);
            end else begin
                check($sformatf("vec%0d_latency", i), k, 0);
            end
        end

        // Backpressure: ADD held for 3 cycles while an XOR waits on in_valid.
        @(negedge clock);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 4'd0;
        in_a = 8'h10;
        in_b = 8'h20;
        @(posedge clock);
        #1;
        in_op = 4'd7;
        in_a = 8'hF0;
        in_b = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_hold", {out_valid, outs()}, {1'b1, 8'h30, 8'h00, 4'b0000});
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("bp_xor", {out_valid, outs()}, {1'b1, 8'hCC, 8'h00, 4'b0000});
        @(negedge clock);
        check("bp_drained", out_valid, 0);

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_op = 4'd0;
            in_a = W'(i * 10 + 1);
            in_b = W'(i);
            check("thru_ready", in_ready, 1);
            @(negedge clock);
            check("thru_res", {out_valid, out_result}, {1'b1, W'(i * 11 + 1)});
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("thru_drained", out_valid, 0);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ((op == 4'd8 || op == 4'd9) && $urandom_range(0, 3) == 0) b = W'($urandom_range(0, 1) * W);
            run_op(op, a, b, r, k, rl);
            e = model(op, a, b);
            check($sformatf("rand%0d_op%0d_out", i, op), r, e);
            check($sformatf("rand%0d_op%0d_lat", i, op), k,
                  ((op == 4'd3 || op == 4'd4) && b != 0) ? W : 0);
        end

        // Reset during a divide aborts it.
        @(negedge clock);
        in_valid = 1'b1;
        in_op = 4'd3;
        in_a = 8'd200;
        in_b = 8'd7;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_outputs", {out_valid, outs()}, '0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_ready_after", in_ready, 1);
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        run_op(4'd0, 8'd1, 8'd1, r, k, rl);
        check("abort_next_add", {r, 32'(k)}, {res_t'({8'h02, 8'h00, 4'b0000}), 32'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
